// File: rtl/bisr_remap_ctrl.sv
// bisr_remap_ctrl: built-in self-repair remap controller.
//
// Collects faulty addresses from a BIST engine into a de-duplicating fault
// table during the log phase. In mission mode every host access that hits a
// logged address goes to a dedicated spare word (entry i -> spare word i);
// all other accesses go to main memory.
//
// Ports:
//   CLK, RST            clock, synchronous active-high reset
//   FAULT_VALID/ADDR    one faulty address per cycle from BIST
//   BIST_DONE           end of logging pulse
//   HOST_*              host request port (1-cycle read latency, no stalls)
//   MAIN_*              main SRAM port (1-cycle synchronous read)
//   SPARE_*             spare SRAM port (1-cycle synchronous read)
//   FAULT_COUNT         number of valid table entries
//   REPAIR_DONE         table final, remapping active
//   REPAIR_FAIL         more unique faults than spare words
module bisr_remap_ctrl #(
  parameter int ADDR_W    = 16,
  parameter int DATA_W    = 8,
  parameter int NUM_SPARE = 32,
  parameter int SPARE_AW  = $clog2(NUM_SPARE)
) (
  input  logic                CLK,
  input  logic                RST,
  input  logic                FAULT_VALID,
  input  logic [ADDR_W-1:0]   FAULT_ADDR,
  input  logic                BIST_DONE,
  input  logic                HOST_REQ,
  input  logic                HOST_WE,
  input  logic [ADDR_W-1:0]   HOST_ADDR,
  input  logic [DATA_W-1:0]   HOST_WDATA,
  output logic                HOST_READY,
  output logic                HOST_RVALID,
  output logic [DATA_W-1:0]   HOST_RDATA,
  output logic                MAIN_EN,
  output logic                MAIN_WE,
  output logic [ADDR_W-1:0]   MAIN_ADDR,
  output logic [DATA_W-1:0]   MAIN_WDATA,
  input  logic [DATA_W-1:0]   MAIN_RDATA,
  output logic                SPARE_EN,
  output logic                SPARE_WE,
  output logic [SPARE_AW-1:0] SPARE_ADDR,
  output logic [DATA_W-1:0]   SPARE_WDATA,
  input  logic [DATA_W-1:0]   SPARE_RDATA,
  output logic [SPARE_AW:0]   FAULT_COUNT,
  output logic                REPAIR_DONE,
  output logic                REPAIR_FAIL
);

  typedef enum logic [1:0] {S_LOG, S_READY, S_FAIL} state_t;

  state_t              state, state_nxt;
  logic [NUM_SPARE-1:0] ent_vld;
  logic [ADDR_W-1:0]   ent_addr [NUM_SPARE];
  logic [SPARE_AW:0]   count;
  logic                overflow;

  logic                fault_hit, table_full, log_new, log_ovf;
  logic                host_hit;
  logic [SPARE_AW-1:0] host_idx;
  logic                rd_acc, rd_spare;
  logic                vld_p0, hit_p0;

  // Dedup compare of the reported fault against every valid entry.
  always_comb begin
    fault_hit = 1'b0;
    for (int i = 0; i < NUM_SPARE; i++) begin
      if (ent_vld[i] && (ent_addr[i] == FAULT_ADDR)) fault_hit = 1'b1;
    end
  end

  assign table_full = (count == (SPARE_AW+1)'(NUM_SPARE));
  assign log_new    = (state == S_LOG) && FAULT_VALID && !fault_hit && !table_full;
  assign log_ovf    = (state == S_LOG) && FAULT_VALID && !fault_hit && table_full;

  // Host lookup; scanning downward lets the lowest matching index win.
  always_comb begin
    host_hit = 1'b0;
    host_idx = '0;
    for (int i = NUM_SPARE - 1; i >= 0; i--) begin
      if (ent_vld[i] && (ent_addr[i] == HOST_ADDR)) begin
        host_hit = 1'b1;
        host_idx = SPARE_AW'(i);
      end
    end
  end

  // Control state: FSM, table valid bits, count, overflow, read valid.
  always_ff @(posedge CLK) begin
    if (RST) begin
      state    <= S_LOG;
      ent_vld  <= '0;
      count    <= '0;
      overflow <= 1'b0;
      vld_p0   <= 1'b0;
    end else begin
      state  <= state_nxt;
      vld_p0 <= rd_acc;
      if (log_new) begin
        for (int i = 0; i < NUM_SPARE; i++) begin
          if (count == (SPARE_AW+1)'(i)) ent_vld[i] <= 1'b1;
        end
        count <= count + 1'b1;
      end
      if (log_ovf) overflow <= 1'b1;
    end
  end

  // Data state: table addresses and the registered read-return select.
  always_ff @(posedge CLK) begin
    if (log_new) begin
      for (int i = 0; i < NUM_SPARE; i++) begin
        if (count == (SPARE_AW+1)'(i)) ent_addr[i] <= FAULT_ADDR;
      end
    end
    hit_p0 <= rd_spare;
  end

  // Next state and request routing.
  always_comb begin
    state_nxt   = state;
    HOST_READY  = 1'b0;
    REPAIR_DONE = 1'b0;
    REPAIR_FAIL = 1'b0;
    MAIN_EN     = 1'b0;
    MAIN_WE     = 1'b0;
    MAIN_ADDR   = HOST_ADDR;
    MAIN_WDATA  = HOST_WDATA;
    SPARE_EN    = 1'b0;
    SPARE_WE    = 1'b0;
    SPARE_ADDR  = host_idx;
    SPARE_WDATA = HOST_WDATA;
    rd_acc      = 1'b0;
    rd_spare    = 1'b0;
    case (state)
      S_LOG: begin
        // A fault arriving with BIST_DONE still counts toward overflow.
        if (BIST_DONE) state_nxt = (overflow || log_ovf) ? S_FAIL : S_READY;
      end
      S_READY: begin
        HOST_READY  = 1'b1;
        REPAIR_DONE = 1'b1;
        if (HOST_REQ) begin
          rd_acc = !HOST_WE;
          if (host_hit) begin
            SPARE_EN = 1'b1;
            SPARE_WE = HOST_WE;
            rd_spare = !HOST_WE;
          end else begin
            MAIN_EN = 1'b1;
            MAIN_WE = HOST_WE;
          end
        end
      end
      S_FAIL: begin
        HOST_READY  = 1'b1;
        REPAIR_FAIL = 1'b1;
        if (HOST_REQ) begin
          rd_acc  = !HOST_WE;
          MAIN_EN = 1'b1;
          MAIN_WE = HOST_WE;
        end
      end
      default: state_nxt = S_LOG;
    endcase
  end

  // Read return stage
  assign HOST_RVALID = vld_p0;
  assign HOST_RDATA  = !vld_p0 ? '0 : (hit_p0 ? SPARE_RDATA : MAIN_RDATA);
  assign FAULT_COUNT = count;

endmodule

// File: tb/tb_bisr_remap_ctrl.sv
module tb_bisr_remap_ctrl;

  localparam int NS = 4;

  logic        clk = 1'b0;
  logic        rst, fv, bd, req, we;
  logic [15:0] faddr, haddr;
  logic [7:0]  wdata;
  logic        host_ready, host_rvalid;
  logic [7:0]  host_rdata;
  logic        main_en, main_we, spare_en, spare_we;
  logic [15:0] main_addr;
  logic [7:0]  main_wdata, main_rdata, spare_wdata, spare_rdata;
  logic [1:0]  spare_addr;
  logic [2:0]  fault_count;
  logic        repair_done, repair_fail;

  int n_chk = 0;
  int n_fail = 0;

  always #5 clk = ~clk;

  bisr_remap_ctrl #(.ADDR_W(16), .DATA_W(8), .NUM_SPARE(NS)) dut (
    .CLK(clk), .RST(rst), .FAULT_VALID(fv), .FAULT_ADDR(faddr), .BIST_DONE(bd),
    .HOST_REQ(req), .HOST_WE(we), .HOST_ADDR(haddr), .HOST_WDATA(wdata),
    .HOST_READY(host_ready), .HOST_RVALID(host_rvalid), .HOST_RDATA(host_rdata),
    .MAIN_EN(main_en), .MAIN_WE(main_we), .MAIN_ADDR(main_addr), .MAIN_WDATA(main_wdata),
    .MAIN_RDATA(main_rdata), .SPARE_EN(spare_en), .SPARE_WE(spare_we),
    .SPARE_ADDR(spare_addr), .SPARE_WDATA(spare_wdata), .SPARE_RDATA(spare_rdata),
    .FAULT_COUNT(fault_count), .REPAIR_DONE(repair_done), .REPAIR_FAIL(repair_fail)
  );

  // Behavioural SRAMs with 1-cycle synchronous read.
  logic [7:0] main_mem [0:65535];
  logic [7:0] spare_mem [0:NS-1];

  initial begin
    for (int i = 0; i < 65536; i++) main_mem[i] <= 8'h00;
    for (int i = 0; i < NS; i++) spare_mem[i] <= 8'h00;
    main_rdata  <= 8'h00;
    spare_rdata <= 8'h00;
  end

  always @(posedge clk) begin
    if (main_en) begin
      if (main_we) main_mem[main_addr] <= main_wdata;
      else         main_rdata <= main_mem[main_addr];
    end
    if (spare_en) begin
      if (spare_we) spare_mem[spare_addr] <= spare_wdata;
      else          spare_rdata <= spare_mem[spare_addr];
    end
  end

  // Reference model: state 0=LOG 1=READY 2=FAIL, fault list as a queue,
  // expected host-visible memory contents per physical location.
  int          m_state = 0;
  bit          m_ovf = 0;
  bit          m_rv = 0;
  logic [7:0]  m_rd = 8'h00;
  logic [15:0] m_flt [$];
  logic [7:0]  m_main [int];
  logic [7:0]  m_spare [NS];

  function automatic int find_idx(logic [15:0] a);
    for (int i = 0; i < m_flt.size(); i++) if (m_flt[i] == a) return i;
    return -1;
  endfunction

  function automatic logic [7:0] main_val(logic [15:0] a);
    if (m_main.exists(int'(a))) return m_main[int'(a)];
    return 8'h00;
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_check();
    int idx;
    bit acc, sp, mn;
    idx = find_idx(haddr);
    acc = req && (m_state != 0);
    sp  = acc && (m_state == 1) && (idx >= 0);
    mn  = acc && !sp;
    chk("host_ready", 32'(host_ready), 32'(m_state != 0));
    chk("main_en", 32'(main_en), 32'(mn));
    chk("spare_en", 32'(spare_en), 32'(sp));
    if (mn) begin
      chk("main_addr", 32'(main_addr), 32'(haddr));
      chk("main_we", 32'(main_we), 32'(we));
      if (we) chk("main_wdata", 32'(main_wdata), 32'(wdata));
    end
    if (sp) begin
      chk("spare_addr", 32'(spare_addr), 32'(idx));
      chk("spare_we", 32'(spare_we), 32'(we));
      if (we) chk("spare_wdata", 32'(spare_wdata), 32'(wdata));
    end
    chk("host_rvalid", 32'(host_rvalid), 32'(m_rv));
    chk("host_rdata", 32'(host_rdata), m_rv ? 32'(m_rd) : 32'h0);
    chk("fault_count", 32'(fault_count), 32'(m_flt.size()));
    chk("repair_done", 32'(repair_done), 32'(m_state == 1));
    chk("repair_fail", 32'(repair_fail), 32'(m_state == 2));
  endtask

  task automatic model_update();
    int idx;
    bit acc, sp;
    if (rst) begin
      m_flt.delete();
      m_ovf = 0;
      m_state = 0;
      m_rv = 0;
      return;
    end
    idx = find_idx(haddr);
    acc = req && (m_state != 0);
    sp  = acc && (m_state == 1) && (idx >= 0);
    m_rv = acc && !we;
    if (m_rv) m_rd = sp ? m_spare[idx] : main_val(haddr);
    if (acc && we) begin
      if (sp) m_spare[idx] = wdata;
      else    m_main[int'(haddr)] = wdata;
    end
    if (m_state == 0) begin
      if (fv && find_idx(faddr) < 0) begin
        if (m_flt.size() < NS) m_flt.push_back(faddr);
        else m_ovf = 1;
      end
      if (bd) m_state = m_ovf ? 2 : 1;
    end
  endtask

  // Called at the negedge after any extra checks; ends just after the posedge.
  task automatic finish_cycle();
    model_check();
    model_update();
    @(posedge clk);
    #1;
  endtask

  task automatic cyc();
    @(negedge clk);
    finish_cycle();
  endtask

  task automatic drive(input bit r, input bit f, input logic [15:0] fa, input bit b,
                       input bit q, input bit w, input logic [15:0] ha, input logic [7:0] wd);
    rst = r; fv = f; faddr = fa; bd = b; req = q; we = w; haddr = ha; wdata = wd;
  endtask

  typedef struct {
    bit rst, fv, bd, req, we;
    logic [15:0] faddr, haddr;
    logic [7:0]  wd;
    bit e_rdy, e_men, e_sen;
    logic [1:0] e_sa;
    bit e_rv;
    logic [7:0] e_rd;
    int e_cnt;
    bit e_done, e_fail;
  } vec_t;

  vec_t vt [17];

  initial begin
    for (int i = 0; i < NS; i++) m_spare[i] = 8'h00;
    drive(1, 0, 16'h0, 0, 0, 0, 16'h0, 8'h0);

    //          rst fv bd rq we faddr     haddr     wd     rdy men sen sa rv rd    cnt dn fl
    vt[0]  = '{1, 0, 0, 1, 0, 16'h0000, 16'h1234, 8'h00, 0, 0, 0, 2'd0, 0, 8'h00, 0, 0, 0};
    vt[1]  = '{1, 0, 0, 1, 0, 16'h0000, 16'h1234, 8'h00, 0, 0, 0, 2'd0, 0, 8'h00, 0, 0, 0};
    vt[2]  = '{0, 0, 0, 1, 0, 16'h0000, 16'h1234, 8'h00, 0, 0, 0, 2'd0, 0, 8'h00, 0, 0, 0};
    vt[3]  = '{0, 1, 0, 0, 0, 16'h1234, 16'h0000, 8'h00, 0, 0, 0, 2'd0, 0, 8'h00, 0, 0, 0};
    vt[4]  = '{0, 1, 0, 0, 0, 16'h00FF, 16'h0000, 8'h00, 0, 0, 0, 2'd0, 0, 8'h00, 1, 0, 0};
    vt[5]  = '{0, 1, 0, 0, 0, 16'h1234, 16'h0000, 8'h00, 0, 0, 0, 2'd0, 0, 8'h00, 2, 0, 0};
    vt[6]  = '{0, 0, 1, 0, 0, 16'h0000, 16'h0000, 8'h00, 0, 0, 0, 2'd0, 0, 8'h00, 2, 0, 0};
    vt[7]  = '{0, 0, 0, 1, 1, 16'h0000, 16'h00FF, 8'hA5, 1, 0, 1, 2'd1, 0, 8'h00, 2, 1, 0};
    vt[8]  = '{0, 0, 0, 1, 0, 16'h0000, 16'h00FF, 8'h00, 1, 0, 1, 2'd1, 0, 8'h00, 2, 1, 0};
    vt[9]  = '{0, 0, 0, 1, 1, 16'h0000, 16'h0100, 8'h3C, 1, 1, 0, 2'd0, 1, 8'hA5, 2, 1, 0};
    vt[10] = '{0, 0, 0, 1, 1, 16'h0000, 16'h1234, 8'h5A, 1, 0, 1, 2'd0, 0, 8'h00, 2, 1, 0};
    vt[11] = '{0, 0, 0, 1, 0, 16'h0000, 16'h0100, 8'h00, 1, 1, 0, 2'd0, 0, 8'h00, 2, 1, 0};
    vt[12] = '{0, 0, 0, 1, 0, 16'h0000, 16'h1234, 8'h00, 1, 0, 1, 2'd0, 1, 8'h3C, 2, 1, 0};
    vt[13] = '{0, 0, 0, 1, 0, 16'h0000, 16'h0100, 8'h00, 1, 1, 0, 2'd0, 1, 8'h5A, 2, 1, 0};
    vt[14] = '{0, 0, 0, 1, 0, 16'h0000, 16'h00FF, 8'h00, 1, 0, 1, 2'd1, 1, 8'h3C, 2, 1, 0};
    vt[15] = '{0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00, 1, 0, 0, 2'd0, 1, 8'hA5, 2, 1, 0};
    vt[16] = '{0, 0, 0, 0, 0, 16'h0000, 16'h0000, 8'h00, 1, 0, 0, 2'd0, 0, 8'h00, 2, 1, 0};

    @(posedge clk);
    #1;

    // Table: reset, logging with dedup, remap, miss path, alternating reads.
    for (int i = 0; i < 17; i++) begin
      drive(vt[i].rst, vt[i].fv, vt[i].faddr, vt[i].bd, vt[i].req, vt[i].we,
            vt[i].haddr, vt[i].wd);
      @(negedge clk);
      chk($sformatf("v%0d host_ready", i), 32'(host_ready), 32'(vt[i].e_rdy));
      chk($sformatf("v%0d main_en", i), 32'(main_en), 32'(vt[i].e_men));
      chk($sformatf("v%0d spare_en", i), 32'(spare_en), 32'(vt[i].e_sen));
      if (vt[i].e_sen) chk($sformatf("v%0d spare_addr", i), 32'(spare_addr), 32'(vt[i].e_sa));
      chk($sformatf("v%0d host_rvalid", i), 32'(host_rvalid), 32'(vt[i].e_rv));
      chk($sformatf("v%0d host_rdata", i), 32'(host_rdata), 32'(vt[i].e_rd));
      chk($sformatf("v%0d fault_count", i), 32'(fault_count), 32'(vt[i].e_cnt));
      chk($sformatf("v%0d repair_done", i), 32'(repair_done), 32'(vt[i].e_done));
      chk($sformatf("v%0d repair_fail", i), 32'(repair_fail), 32'(vt[i].e_fail));
      finish_cycle();
    end

    // Mid-read reset: read accepted, RST the next cycle.
    drive(0, 0, 16'h0, 0, 1, 0, 16'h00FF, 8'h00);
    cyc();
    drive(1, 0, 16'h0, 0, 0, 0, 16'h0000, 8'h00);
    cyc();
    drive(0, 0, 16'h0, 0, 0, 0, 16'h0000, 8'h00);
    @(negedge clk);
    chk("midrst rvalid", 32'(host_rvalid), 32'h0);
    chk("midrst count", 32'(fault_count), 32'h0);
    chk("midrst ready", 32'(host_ready), 32'h0);
    finish_cycle();
    drive(0, 0, 16'h0, 1, 0, 0, 16'h0000, 8'h00);
    cyc();
    drive(0, 0, 16'h0, 0, 1, 0, 16'h00FF, 8'h00);
    @(negedge clk);
    chk("midrst old fault main_en", 32'(main_en), 32'h1);
    chk("midrst old fault spare_en", 32'(spare_en), 32'h0);
    finish_cycle();

    // Overflow: 5th unique fault arrives together with BIST_DONE.
    drive(1, 0, 16'h0, 0, 0, 0, 16'h0, 8'h0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 16'h0010 * 16'(i + 1), 0, 0, 0, 16'h0, 8'h0);
      cyc();
    end
    drive(0, 1, 16'h0050, 1, 0, 0, 16'h0, 8'h0);
    cyc();
    drive(0, 0, 16'h0, 0, 1, 0, 16'h0010, 8'h0);
    @(negedge clk);
    chk("ovf count", 32'(fault_count), 32'h4);
    chk("ovf repair_fail", 32'(repair_fail), 32'h1);
    chk("ovf repair_done", 32'(repair_done), 32'h0);
    chk("ovf main_en", 32'(main_en), 32'h1);
    chk("ovf spare_en", 32'(spare_en), 32'h0);
    finish_cycle();

    // Exact fill, then a duplicate alongside BIST_DONE must not overflow.
    drive(1, 0, 16'h0, 0, 0, 0, 16'h0, 8'h0);
    cyc();
    for (int i = 0; i < 4; i++) begin
      drive(0, 1, 16'h00A0 + 16'(i), 0, 0, 0, 16'h0, 8'h0);
      cyc();
    end
    drive(0, 1, 16'h00A1, 1, 0, 0, 16'h0, 8'h0);
    cyc();
    drive(0, 0, 16'h0, 0, 1, 1, 16'h00A3, 8'h77);
    @(negedge clk);
    chk("fill repair_done", 32'(repair_done), 32'h1);
    chk("fill count", 32'(fault_count), 32'h4);
    chk("fill spare_en", 32'(spare_en), 32'h1);
    chk("fill spare_addr", 32'(spare_addr), 32'h3);
    finish_cycle();
    drive(0, 0, 16'h0, 0, 1, 0, 16'h00A3, 8'h00);
    cyc();
    drive(0, 0, 16'h0, 0, 0, 0, 16'h0000, 8'h00);
    @(negedge clk);
    chk("fill readback", 32'(host_rdata), 32'h77);
    finish_cycle();

    // Randomized episodes checked against the reference model.
    for (int ep = 0; ep < 8; ep++) begin
      drive(1, 0, 16'h0, 0, 0, 0, 16'h0, 8'h0);
      cyc();
      for (int k = 0; k < int'($urandom_range(0, 8)); k++) begin
        drive(0, $urandom_range(0, 3) != 0, 16'($urandom_range(0, 5)), 0,
              1'($urandom), 1'($urandom), 16'($urandom_range(0, 7)), 8'($urandom));
        cyc();
      end
      drive(0, 1'($urandom), 16'($urandom_range(0, 5)), 1, 0, 0, 16'h0, 8'h0);
      cyc();
      for (int k = 0; k < 60; k++) begin
        drive(0, 1'($urandom), 16'($urandom_range(0, 7)), ($urandom_range(0, 9) == 0),
              ($urandom_range(0, 3) != 0), 1'($urandom), 16'($urandom_range(0, 7)),
              8'($urandom));
        cyc();
      end
    end

    drive(0, 0, 16'h0, 0, 0, 0, 16'h0, 8'h0);
    cyc();
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
